// File: rtl/replica_unpacker_if.sv
// +--------------------------------------------------------------------------+
// | replica_unpacker_if : packed-word in / byte-stream out bus               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface replica_unpacker_if #(
  parameter int WIDTH = 8,
  parameter int N_REP = 2,
  parameter int CNT_W = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH*(N_REP+1)-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic                         out_err;
  logic [CNT_W-1:0]             err_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err, err_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/replica_unpacker.sv
// +--------------------------------------------------------------------------+
// | replica_unpacker : splits {X, {N_REP{A}}} into bytes X, A; flags replicas |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module replica_unpacker #(
  parameter int WIDTH = 8,
  parameter int N_REP = 2,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  replica_unpacker_if.slave   bus
);

  localparam int              IN_W    = WIDTH * (N_REP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_X = 2'd1,
    EMIT_A = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic              mis_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_last_q;
  logic              out_err_q;
  logic [CNT_W-1:0]  err_cnt_q;

  logic [WIDTH-1:0]  x_in;
  logic [WIDTH-1:0]  a_in;
  logic [N_REP-2:0]  diff;
  logic              mis_in;
  logic              accept;

  assign x_in = bus.in_data[IN_W-1 -: WIDTH];
  assign a_in = bus.in_data[N_REP*WIDTH-1 -: WIDTH];

  // Every lower replica is compared against the top one, which is the byte emitted.
  generate
    for (genvar i = 0; i < N_REP - 1; i++) begin : g_cmp
      assign diff[i] = (bus.in_data[i*WIDTH +: WIDTH] != a_in);
    end
  endgenerate

  assign mis_in = |diff;

  assign bus.in_ready = !rst && ((state_q == IDLE) ||
                                 ((state_q == EMIT_A) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      mis_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if ((state_q == EMIT_A) && bus.out_ready && out_err_q && (err_cnt_q != CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end

      if (accept) begin
        a_q         <= a_in;
        mis_q       <= mis_in;
        out_valid_q <= 1'b1;
        out_data_q  <= x_in;
        out_last_q  <= 1'b0;
        out_err_q   <= 1'b0;
        state_q     <= EMIT_X;
      end else begin
        case (state_q)
          EMIT_X: begin
            if (bus.out_ready) begin
              out_data_q <= a_q;
              out_last_q <= 1'b1;
              out_err_q  <= mis_q;
              state_q    <= EMIT_A;
            end
          end
          EMIT_A: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_err_q   <= 1'b0;
              state_q     <= IDLE;
            end
          end
          IDLE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_replica_unpacker.sv
// +--------------------------------------------------------------------------+
// | tb_replica_unpacker : scoreboard bench for replica_unpacker              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_replica_unpacker;

  localparam int WIDTH = 8;
  localparam int N_REP = 2;
  localparam int CNT_W = 8;
  localparam int IN_W  = WIDTH * (N_REP + 1);

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             last;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bp_mode  = 2;   // 0: ready always high, 1: random ready, 2: driven by main
  int   cnt_model = 0;
  exp_t exp_q[$];
  int   xcyc[$];

  replica_unpacker_if #(.WIDTH(WIDTH), .N_REP(N_REP), .CNT_W(CNT_W)) bus ();

  replica_unpacker #(.WIDTH(WIDTH), .N_REP(N_REP), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: X is the top field, the emitted A is the highest replica, and
  // the word is bad if any replica differs from that one.
  task automatic push_expected(input logic [IN_W-1:0] w);
    exp_t ex, ea;
    logic [WIDTH-1:0] a_top;
    logic [IN_W-1:0]  sh;
    logic             bad = 1'b0;
    sh    = w >> (N_REP * WIDTH);
    ex.d  = sh[WIDTH-1:0];
    ex.last = 1'b0;
    ex.err  = 1'b0;
    sh    = w >> ((N_REP - 1) * WIDTH);
    a_top = sh[WIDTH-1:0];
    for (int i = 0; i < N_REP; i++) begin
      sh = w >> (i * WIDTH);
      if (sh[WIDTH-1:0] != a_top) bad = 1'b1;
    end
    ea.d = a_top;
    ea.last = 1'b1;
    ea.err  = bad;
    exp_q.push_back(ex);
    exp_q.push_back(ea);
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0)      bus.out_ready = 1'b1;
    else if (bp_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops and compares every byte transfer, tracks err_cnt and stall stability.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_d;
  logic             prev_last, prev_err;
  always @(negedge clk) begin
    if (rst) begin
      cnt_model  = 0;
      prev_stall = 1'b0;
    end else begin
      check("err_cnt", 32'(bus.err_cnt), 32'(cnt_model));
      if (prev_stall) begin
        check("hold_data", {bus.out_valid, bus.out_last, bus.out_err, 21'd0, bus.out_data},
                           {1'b1, prev_last, prev_err, 21'd0, prev_d});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte", {bus.out_last, bus.out_err, 22'd0, bus.out_data},
                        {e.last, e.err, 22'd0, e.d});
          if (e.last && e.err && cnt_model < (1 << CNT_W) - 1) cnt_model++;
        end
        xcyc.push_back(cyc);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_last  = bus.out_last;
      prev_err   = bus.out_err;
    end
  end

  task automatic send(input logic [IN_W-1:0] w);
    bit acc = 1'b0;
    int n   = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) push_expected(w);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int x0;
    logic [WIDTH-1:0] x, a;
    logic [IN_W-1:0]  w;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_last_err",  {30'd0, bus.out_last, bus.out_err}, 32'd0);
    check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bp_mode = 0;
    bus.out_ready = 1'b1;

    send(24'hA5_3C_3C);
    idle();
    drain();
    send(24'h12_34_35);
    idle();
    drain();
    check("err_cnt_after_mismatch", 32'(bus.err_cnt), 32'd1);

    bp_mode = 2;
    bus.out_ready = 1'b0;
    send(24'h7E_01_01);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("stall_x_data", 32'(bus.out_data), 32'h7E);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_a_data", {bus.out_valid, bus.out_last, 22'd0, bus.out_data}, {2'b11, 22'd0, 8'h01});
    bus.out_ready = 1'b1;
    bp_mode = 0;
    drain();

    x0 = xcyc.size();
    for (int i = 0; i < 4; i++) send({8'(8'h40 + i), 8'(8'h10 * i), 8'(8'h10 * i)});
    idle();
    drain();
    check("throughput_8_bytes", 32'(xcyc.size() - x0), 32'd8);
    if (xcyc.size() - x0 >= 8) check("throughput_span", 32'(xcyc[x0+7] - xcyc[x0]), 32'd7);

    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      a = 8'($urandom);
      w = {x, a, a};
      if ($urandom_range(0, 1) == 1) w[$urandom_range(0, 7)] ^= 1'b1;
      send(w);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain();

    bp_mode = 0;
    for (int i = 0; i < 260; i++) begin
      a = 8'($urandom);
      send({8'(i), a, ~a});
    end
    idle();
    drain();
    check("err_cnt_saturated", 32'(bus.err_cnt), 32'hFF);

    bp_mode = 2;
    bus.out_ready = 1'b0;
    send(24'hC3_55_56);
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bp_mode = 0;
    bus.out_ready = 1'b1;
    send(24'h9A_66_66);
    idle();
    drain();
    check("post_rst_err_cnt", 32'(bus.err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
